// File: rtl/core_pkg.sv
// core_pkg: shared types and sizing helpers for the core input skew stage.
package core_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FIN} skew_state_t;

    // Wavefront counter must reach len+ROWS-1 at the largest len without wrapping.
    function automatic int skew_cnt_w(input int lenw, input int rows);
        return lenw + $clog2(rows) + 1;
    endfunction

    localparam int SKEW_CNT_W_DEFAULT = skew_cnt_w(16, 8);

endpackage

// File: rtl/core_input_skew.sv
// core_input_skew: pops per-row FIFOs and drives the systolic array rows with a
// triangular skew; any blocked active row or array stall freezes the whole wavefront.
module core_input_skew
    import core_pkg::*;
#(
    parameter int ROWS    = 8,
    parameter int INWIDTH = 8,
    parameter int LENW    = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [LENW-1:0]         len,
    input  logic [ROWS-1:0]         buf_empty,
    input  logic [ROWS*INWIDTH-1:0] buf_dout,
    output logic [ROWS-1:0]         buf_read,
    input  logic                    arr_stall,
    output logic [ROWS*INWIDTH-1:0] arr_din,
    output logic [ROWS-1:0]         arr_valid,
    output logic                    busy,
    output logic                    done
);

    localparam int TW = skew_cnt_w(LENW, ROWS);

    skew_state_t             state_q, state_d;
    logic [TW-1:0]           t_q, t_d;
    logic [LENW-1:0]         len_q, len_d;
    logic [ROWS-1:0]         valid_q, valid_d;
    logic [ROWS*INWIDTH-1:0] din_q, din_d;
    logic [ROWS-1:0]         active;
    logic                    adv, go, last;

    // Row i is live on wavefront steps i .. i+len_q-1.
    for (genvar i = 0; i < ROWS; i++) begin : g_row
        assign active[i] = (t_q >= TW'(i)) && (t_q < TW'(i) + TW'(len_q));
        assign din_d[i*INWIDTH +: INWIDTH] = adv ? (active[i] ? buf_dout[i*INWIDTH +: INWIDTH] : '0)
                                                 : din_q[i*INWIDTH +: INWIDTH];
    end

    assign go      = (state_q == IDLE) && start && (len != '0);
    assign last    = t_q == TW'(len_q) + TW'(ROWS - 2);
    assign adv     = (state_q == RUN) && !arr_stall && ((active & buf_empty) == '0);
    assign valid_d = adv ? active : (arr_stall ? valid_q : '0);
    assign len_d   = go ? len : len_q;
    assign t_d     = go ? '0 : (adv ? t_q + TW'(1) : t_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            t_q     <= '0;
            len_q   <= '0;
            valid_q <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            din_q   <= din_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? ((len != '0) ? RUN : FIN) : IDLE;
            RUN:     state_d = (adv && last) ? FIN : RUN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        buf_read = adv ? active : '0;
        busy     = state_q != IDLE;
        done     = state_q == FIN;
    end

    assign arr_valid = valid_q;
    assign arr_din   = din_q;

endmodule

// File: tb/tb_core_input_skew.sv
// tb_core_input_skew: table-driven scenarios plus randomized tiles checked against
// a wavefront model that predicts each row's stream element from its tile index.
module tb_core_input_skew;

    localparam int R = 4;
    localparam int W = 8;
    localparam int L = 16;

    logic             clk, rstn, start, arr_stall;
    logic [L-1:0]     len;
    logic [R-1:0]     buf_empty, buf_read, arr_valid;
    logic [R*W-1:0]   buf_dout, arr_din;
    logic             busy, done;

    core_input_skew #(.ROWS(R), .INWIDTH(W), .LENW(L)) dut (
        .clk(clk), .rstn(rstn), .start(start), .len(len),
        .buf_empty(buf_empty), .buf_dout(buf_dout), .buf_read(buf_read),
        .arr_stall(arr_stall), .arr_din(arr_din), .arr_valid(arr_valid),
        .busy(busy), .done(done)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic          ld;
        logic          st;
        logic [L-1:0]  ln;
        logic          sl;
        logic [R-1:0]  fe;
        logic [R-1:0]  ev;
        logic [R-1:0]  er;
        logic          eb;
        logic          ed;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] q[R][$];
    logic [7:0] strm[R][$];
    int         pcnt[R];
    logic [R-1:0] fmask;
    int         nchk, nerr;
    int         mph, k, mlen, nadv;
    logic [R-1:0]   mval;
    logic [R*W-1:0] mdin;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic add(input logic ld, input logic st, input int ln, input logic sl,
                       input logic [R-1:0] fe, input logic [R-1:0] ev, input logic [R-1:0] er,
                       input logic eb, input logic ed);
        vec_t v;
        v.ld = ld; v.st = st; v.ln = L'(ln); v.sl = sl; v.fe = fe;
        v.ev = ev; v.er = er; v.eb = eb; v.ed = ed;
        tbl.push_back(v);
    endtask

    task automatic drive_fifo();
        for (int i = 0; i < R; i++) begin
            buf_empty[i] = fmask[i] || (q[i].size() == 0);
            buf_dout[i*W +: W] = (q[i].size() > 0) ? q[i][0] : 8'h00;
        end
    endtask

    task automatic load(input int n);
        logic [7:0] x;
        for (int i = 0; i < R; i++) begin
            q[i].delete();
            strm[i].delete();
            pcnt[i] = 0;
            for (int j = 0; j < n; j++) begin
                x = 8'($urandom);
                q[i].push_back(x);
                strm[i].push_back(x);
            end
        end
    endtask

    task automatic model_reset();
        mph = 0; k = 0; mlen = 0; mval = '0; mdin = '0;
    endtask

    // One clock: apply inputs at the falling edge, check, then advance the model.
    task automatic cyc(input logic st, input int ln, input logic sl, input logic [R-1:0] fe,
                       output logic [R-1:0] o_rd, output logic [R-1:0] o_val,
                       output logic o_busy, output logic o_done);
        logic [R-1:0] act, pops;
        logic adv;
        int ph;
        start = st; len = L'(ln); arr_stall = sl; fmask = fe;
        drive_fifo();
        #1;
        act = '0;
        if (mph == 1)
            for (int i = 0; i < R; i++)
                if (k >= i && k < i + mlen) act[i] = 1'b1;
        adv = (mph == 1) && !sl && ((act & buf_empty) == '0);
        chk("buf_read", 64'(buf_read), 64'(adv ? act : '0));
        chk("arr_valid", 64'(arr_valid), 64'(mval));
        chk("arr_din", 64'(arr_din), 64'(mdin));
        chk("busy", 64'(busy), 64'(mph != 0));
        chk("done", 64'(done), 64'(mph == 2));
        o_rd = buf_read; o_val = arr_valid; o_busy = busy; o_done = done;
        pops = buf_read;
        ph = mph;
        if (adv) begin
            mval = act;
            for (int i = 0; i < R; i++)
                mdin[i*W +: W] = act[i] ? strm[i][k-i] : 8'h00;
            k++;
            nadv++;
            if (k == mlen + R - 1) mph = 2;
        end else if (!sl) begin
            mval = '0;
        end
        if (ph == 0 && st) begin
            if (ln != 0) begin mph = 1; k = 0; mlen = ln; end
            else mph = 2;
        end else if (ph == 2) begin
            mph = 0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < R; i++)
            if (pops[i]) begin
                if (q[i].size() > 0) void'(q[i].pop_front());
                pcnt[i]++;
            end
        @(negedge clk);
    endtask

    task automatic chk_pops(input string nm, input int e);
        for (int i = 0; i < R; i++) chk(nm, 64'(pcnt[i]), 64'(e));
    endtask

    initial begin
        logic [R-1:0] r, v;
        logic b, d;
        int plen, ln, n;
        nchk = 0; nerr = 0; nadv = 0;
        rstn = 0; start = 0; len = '0; arr_stall = 0; fmask = '0;
        load(0);
        model_reset();
        drive_fifo();
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(arr_valid), 64'(0));
        chk("rst_din", 64'(arr_din), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_read", 64'(buf_read), 64'(0));
        rstn = 1;
        @(negedge clk);

        // Plain tile, with a start pulse in RUN that must be ignored.
        add(1,1,3,0,4'h0, 4'h0,4'h0,0,0);
        add(0,0,3,0,4'h0, 4'h0,4'h1,1,0);
        add(0,0,3,0,4'h0, 4'h1,4'h3,1,0);
        add(0,1,7,0,4'h0, 4'h3,4'h7,1,0);
        add(0,0,3,0,4'h0, 4'h7,4'he,1,0);
        add(0,0,3,0,4'h0, 4'he,4'hc,1,0);
        add(0,0,3,0,4'h0, 4'hc,4'h8,1,0);
        add(0,0,3,0,4'h0, 4'h8,4'h0,1,1);
        add(0,0,3,0,4'h0, 4'h0,4'h0,0,0);
        // Row 2 underflows for three cycles at t=2.
        add(1,1,3,0,4'h0, 4'h0,4'h0,0,0);
        add(0,0,3,0,4'h0, 4'h0,4'h1,1,0);
        add(0,0,3,0,4'h0, 4'h1,4'h3,1,0);
        add(0,0,3,0,4'h4, 4'h3,4'h0,1,0);
        add(0,0,3,0,4'h4, 4'h0,4'h0,1,0);
        add(0,0,3,0,4'h4, 4'h0,4'h0,1,0);
        add(0,0,3,0,4'h0, 4'h0,4'h7,1,0);
        add(0,0,3,0,4'h0, 4'h7,4'he,1,0);
        add(0,0,3,0,4'h0, 4'he,4'hc,1,0);
        add(0,0,3,0,4'h0, 4'hc,4'h8,1,0);
        add(0,0,3,0,4'h0, 4'h8,4'h0,1,1);
        add(0,0,3,0,4'h0, 4'h0,4'h0,0,0);
        // Array stall for two cycles while 0111 is presented.
        add(1,1,3,0,4'h0, 4'h0,4'h0,0,0);
        add(0,0,3,0,4'h0, 4'h0,4'h1,1,0);
        add(0,0,3,0,4'h0, 4'h1,4'h3,1,0);
        add(0,0,3,0,4'h0, 4'h3,4'h7,1,0);
        add(0,0,3,1,4'h0, 4'h7,4'h0,1,0);
        add(0,0,3,1,4'h0, 4'h7,4'h0,1,0);
        add(0,0,3,0,4'h0, 4'h7,4'he,1,0);
        add(0,0,3,0,4'h0, 4'he,4'hc,1,0);
        add(0,0,3,0,4'h0, 4'hc,4'h8,1,0);
        add(0,0,3,0,4'h0, 4'h8,4'h0,1,1);
        add(0,0,3,0,4'h0, 4'h0,4'h0,0,0);
        // Zero-length tile.
        add(1,1,0,0,4'h0, 4'h0,4'h0,0,0);
        add(0,0,0,0,4'h0, 4'h0,4'h0,1,1);
        add(0,0,0,0,4'h0, 4'h0,4'h0,0,0);

        plen = -1;
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].ld) begin
                if (plen >= 0) chk_pops("tbl_pops", plen);
                load(3);
                plen = int'(tbl[i].ln);
            end
            cyc(tbl[i].st, int'(tbl[i].ln), tbl[i].sl, tbl[i].fe, r, v, b, d);
            chk($sformatf("tbl%0d_read", i), 64'(r), 64'(tbl[i].er));
            chk($sformatf("tbl%0d_valid", i), 64'(v), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d_busy", i), 64'(b), 64'(tbl[i].eb));
            chk($sformatf("tbl%0d_done", i), 64'(d), 64'(tbl[i].ed));
        end
        chk_pops("tbl_pops", plen);

        // Randomized tiles with stalls, underflows and stray starts.
        for (int t = 0; t < 25; t++) begin
            ln = $urandom_range(1, 6);
            load(ln);
            cyc(1, ln, 0, '0, r, v, b, d);
            for (n = 0; mph != 0 && n < 300; n++)
                cyc(($urandom % 7) == 0, $urandom_range(0, 9), ($urandom % 5) == 0,
                    {($urandom%6)==0, ($urandom%6)==0, ($urandom%6)==0, ($urandom%6)==0},
                    r, v, b, d);
            if (mph != 0) begin
                nchk++; nerr++;
                $display("FAIL tile_timeout: tile %0d still busy after %0d cycles", t, n);
                model_reset();
            end
            chk_pops("rand_pops", ln);
            for (int i = 0; i < R; i++) chk("rand_left", 64'(q[i].size()), 64'(0));
        end

        // Asynchronous reset in the middle of a tile.
        load(3);
        cyc(1, 3, 0, '0, r, v, b, d);
        for (n = 0; !(mph == 1 && k == 3) && n < 50; n++) cyc(0, 0, 0, '0, r, v, b, d);
        chk("pre_rst_t", 64'(k), 64'(3));
        rstn = 0;
        #1;
        chk("mid_rst_valid", 64'(arr_valid), 64'(0));
        chk("mid_rst_din", 64'(arr_din), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        chk("mid_rst_read", 64'(buf_read), 64'(0));
        model_reset();
        @(negedge clk);
        rstn = 1;
        @(negedge clk);
        load(2);
        nadv = 0;
        cyc(1, 2, 0, '0, r, v, b, d);
        for (n = 0; mph != 0 && n < 50; n++) cyc(0, 0, 0, '0, r, v, b, d);
        chk("post_rst_adv", 64'(nadv), 64'(5));
        chk_pops("post_rst_pops", 2);
        cyc(0, 0, 0, '0, r, v, b, d);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
